// File: rtl/ant_pkg.sv
// Shared types and default widths for the instruction fetch front-end.
package ant_pkg;

  localparam int INSTR_WIDTH = 16;
  localparam int ADDR_WIDTH  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Small prefetch FIFO of {instr, pc} entries; flush wins over push.
module fetch_fifo
  import ant_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty;
  // Masking keeps the head at zero whenever nothing valid is stored.
  assign head    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  overflow_chk: assert property (@(posedge clock) disable iff (!reset)
    !(do_push && !do_pop && (count_reg == CNT_W'(DEPTH))));

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front-end: PC, one-deep in-flight tracking, issue throttling and redirect flush.
module instruction_fetch #(
  parameter int INSTR_WIDTH = ant_pkg::INSTR_WIDTH,
  parameter int ADDR_WIDTH  = ant_pkg::ADDR_WIDTH,
  parameter int DEPTH       = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fetch_en,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   imem_en,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc
);

  import ant_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  fetch_state_t          state_reg;
  fetch_state_t          state_next;
  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  inflight_reg;
  logic [ADDR_WIDTH-1:0] inflight_pc_reg;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic                  pop;
  logic                  issue;
  logic [OCC_W-1:0]      occupancy;
  fetch_entry_t          push_entry;
  fetch_entry_t          head_entry;

  assign pop       = instr_valid && instr_ready;
  // Slots already committed once this cycle's pop and the pending response settle.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_reg) - OCC_W'(pop);

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    pc_next    = pc_reg;
    case (state_reg)
      IDLE:    if (fetch_en)  state_next = RUN;
      RUN:     if (!fetch_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (state_reg == RUN && !redirect_valid && occupancy < OCC_W'(DEPTH)) issue = 1'b1;
    if (redirect_valid)  pc_next = redirect_pc;
    else if (issue)      pc_next = pc_reg + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      inflight_reg <= issue;
      if (issue) inflight_pc_reg <= pc_reg;
    end
  end

  assign push_entry.instr = imem_rdata;
  assign push_entry.pc    = inflight_pc_reg;

  // A redirect flushes the FIFO, which also drops the response landing this cycle.
  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight_reg),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .head      (head_entry),
    .empty     (fifo_empty)
  );

  assign imem_en     = issue;
  assign imem_addr   = pc_reg;
  assign instr_valid = !fifo_empty;
  assign instr       = head_entry.instr;
  assign instr_pc    = head_entry.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed per-cycle vector table plus hand sequences for async reset and restart.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  instr_pc;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Synchronous memory model: word = addr ^ 16'hA500, one-cycle latency.
  always @(posedge clock) begin
    if (imem_en) imem_rdata <= {8'h00, imem_addr} ^ 16'hA500;
  end

  instruction_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  typedef struct {
    logic       rst_n;
    logic       fen;
    logic       rv;
    logic [7:0] rpc;
    logic       rdy;
    logic       e_en;
    logic [7:0] e_addr;
    logic       e_val;
    logic [7:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst_n, input logic fen, input logic rv,
                              input logic [7:0] rpc, input logic rdy, input logic e_en,
                              input logic [7:0] e_addr, input logic e_val, input logic [7:0] e_pc);
    vec_t v;
    v.rst_n = rst_n; v.fen = fen; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_en = e_en; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    logic seen;

    reset = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 8'h00; instr_ready = 1'b0;

    //                rst fen rv rpc    rdy  en addr   val pc
    vecs.push_back(mk(0, 0, 0, 8'h00, 1,  0, 8'h00, 0, 8'h00)); // reset state
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  0, 8'h00, 0, 8'h00)); // IDLE, going RUN
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h01, 0, 8'h00));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h02, 1, 8'h00)); // first valid
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h03, 1, 8'h01));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h04, 1, 8'h02));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h05, 1, 8'h03));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h06, 1, 8'h04));
    for (int k = 0; k < 6; k++)                                   // back-pressure
      vecs.push_back(mk(1, 1, 0, 8'h00, 0, 0, 8'h07, 1, 8'h05));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h07, 1, 8'h05));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h08, 1, 8'h06));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h09, 1, 8'h07));
    vecs.push_back(mk(1, 1, 1, 8'h40, 0,  0, 8'h0A, 1, 8'h08)); // redirect R
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h40, 0, 8'h00));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h41, 0, 8'h00));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h42, 1, 8'h40)); // R+3
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h43, 1, 8'h41));
    vecs.push_back(mk(1, 1, 1, 8'hFE, 1,  0, 8'h44, 1, 8'h42)); // redirect with pop
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'hFE, 0, 8'h00));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'hFF, 0, 8'h00));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h00, 1, 8'hFE)); // wrap
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h01, 1, 8'hFF));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h02, 1, 8'h00));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h03, 1, 8'h01));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1,  1, 8'h04, 1, 8'h02)); // fetch_en low
    vecs.push_back(mk(1, 0, 0, 8'h00, 1,  0, 8'h05, 1, 8'h03));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1,  0, 8'h05, 1, 8'h04));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1,  0, 8'h05, 0, 8'h00));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  0, 8'h05, 0, 8'h00));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h05, 0, 8'h00)); // resume
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h06, 0, 8'h00));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h07, 1, 8'h05));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0,  0, 8'h08, 1, 8'h06));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0,  0, 8'h08, 1, 8'h06)); // FIFO full
    vecs.push_back(mk(0, 1, 0, 8'h00, 1,  0, 8'h00, 0, 8'h00)); // async reset
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h01, 0, 8'h00));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h02, 1, 8'h00));
    vecs.push_back(mk(1, 1, 0, 8'h00, 1,  1, 8'h03, 1, 8'h01));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(posedge clock);
      #1;
      reset          = v.rst_n;
      fetch_en       = v.fen;
      redirect_valid = v.rv;
      redirect_pc    = v.rpc;
      instr_ready    = v.rdy;
      @(negedge clock);
      check("imem_en", i, 32'(imem_en), 32'(v.e_en));
      check("imem_addr", i, 32'(imem_addr), 32'(v.e_addr));
      check("instr_valid", i, 32'(instr_valid), 32'(v.e_val));
      if (v.e_val) begin
        check("instr", i, 32'(instr), 32'({8'hA5, v.e_pc}));
        check("instr_pc", i, 32'(instr_pc), 32'(v.e_pc));
      end
      if (!v.rst_n) begin
        check("reset_instr", i, 32'(instr), 32'(0));
        check("reset_instr_pc", i, 32'(instr_pc), 32'(0));
      end
      $display("step %0d: rst_n=%0b en=%0b addr=%02h valid=%0b instr=%04h pc=%02h",
               i, reset, imem_en, imem_addr, instr_valid, instr, instr_pc);
    end

    // Fill the FIFO, then drop reset between clock edges.
    @(posedge clock); #1 instr_ready = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock);
    check("full_valid", 100, 32'(instr_valid), 32'(1));
    check("full_head_pc", 100, 32'(instr_pc), 32'(8'h02));
    #2 reset = 1'b0;
    #1;
    check("async_valid", 101, 32'(instr_valid), 32'(0));
    check("async_en", 101, 32'(imem_en), 32'(0));
    check("async_addr", 101, 32'(imem_addr), 32'(0));
    $display("async reset: valid=%0b en=%0b addr=%02h", instr_valid, imem_en, imem_addr);

    // Release and confirm fetch restarts at RESET_PC with the expected latency.
    @(posedge clock); #1;
    reset = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clock);
      if (imem_en) seen = 1'b1;
    end
    check("restart_en_seen", 102, 32'(seen), 32'(1));
    check("restart_addr", 102, 32'(imem_addr), 32'(0));
    @(negedge clock);
    @(negedge clock);
    check("restart_valid", 103, 32'(instr_valid), 32'(1));
    check("restart_pc", 103, 32'(instr_pc), 32'(0));
    check("restart_instr", 103, 32'(instr), 32'(16'hA500));
    $display("restart: valid=%0b instr=%04h pc=%02h", instr_valid, instr, instr_pc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
